reg_op_sequencer: RTL and testbench
===================================

Name: reg_op_sequencer

Overview:
- Multi-cycle initiator that drives the mini-CPU register file: accepts one packed register-register instruction per handshake, issues rs1/rs2 reads, computes a 2-bit-opcode ALU result, and writes it back to rd.
- Sits between the instruction source (testbench/fetch stub) and the register file; owns every register-file address, write-enable and write-data signal.

Parameters:
- DATA_W, 8, register and ALU data width.
- ADDR_W, 2, register index width (4 registers); instruction width INSTR_W = 2 + 3*ADDR_W (derived localparam, 8 at defaults).
- COUNT_W, 8, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction available.
- instr_data  input  INSTR_W  packed instruction: [INSTR_W-1 -: 2] opcode, then rd, rs1, rs2 (rs2 in LSBs); default [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
- instr_ready  output  1  sequencer can accept.
- rs1  output  ADDR_W  register-file read address 1.
- rs2  output  ADDR_W  register-file read address 2.
- rd  output  ADDR_W  register-file write address.
- write_en  output  1  register-file write strobe.
- write_data  output  DATA_W  writeback value.
- read_data1  input  DATA_W  register file value at rs1 (combinational read).
- read_data2  input  DATA_W  register file value at rs2.
- zero_flag  output  1  last result == 0.
- carry_flag  output  1  last carry/borrow.
- done  output  1  one-cycle pulse coincident with write_en.
- retired_count  output  COUNT_W  instructions written back.

Behaviour:
- Reset (reset_n low, async): state IDLE; instr_ready=1; rs1/rs2/rd=0; write_en=0; write_data=0; flags=0; done=0; retired_count=0; captured instruction=0.
- FSM states IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each except IDLE.
- IDLE: instr_ready=1 (registered/decoded from state, never from instr_valid). On a clk edge with instr_valid & instr_ready: capture instr_data; go READ. No accept in any other state (instr_ready=0).
- rs1/rs2/rd driven from the captured instruction continuously; they hold their value until the next accept.
- READ: sample read_data1/read_data2 into operand registers A, B at the end of the cycle; go EXEC.
- EXEC: compute on A, B: op 00 ADD {carry,res}=A+B (DATA_W+1 bits); 01 SUB res=A-B mod 2^DATA_W, carry=1 iff A<B (borrow); 10 AND, carry=0; 11 OR, carry=0. Register res into write_data, update zero_flag=(res==0) and carry_flag at the EXEC->WB edge; go WB.
- WB: write_en=1, done=1 for exactly this cycle; write_data/rd stable; retired_count increments at the end of WB (wraps modulo 2^COUNT_W); go IDLE.
- Latency: accept edge -> write_en high 3 cycles later; throughput 1 instruction / 4 cycles minimum. Back-to-back valid: next accept occurs in the cycle after WB.
- Hazard: a write in WB commits before the next READ, so rd==rs1/rs2 of the following instruction always reads the new value; no forwarding needed.
- rd == rs1 == rs2 allowed (e.g. ADD R1,R1,R1 doubles R1).
- write_data and flags hold their last values outside WB; write_en=0 outside WB.
- reset_n asserted mid-instruction (READ/EXEC/WB): immediate return to reset values; no write_en pulse, retired_count not incremented, instruction discarded.
- instr_data changes while not accepted: ignored.

Test Plan:
- Reset then ADD: R1=0x05, R2=0x03; instr 0x36 (ADD rd=R3,rs1=R1,rs2=R2) -> write_en high 3 cycles after accept, rd=3, write_data=0x08, zero=0, carry=0, retired_count=1.
- Carry/zero: R1=0xFF, R2=0x01, ADD rd=R0 (0x06) -> write_data=0x00, zero=1, carry=1.
- Borrow: R1=0x03, R2=0x05, SUB rd=R2 (0x66) -> write_data=0xFE, carry=1, zero=0; SUB R1-R1 -> 0x00, zero=1, carry=0.
- AND/OR: R1=0xF0, R2=0x3C -> AND gives 0x30, OR gives 0xFC, carry=0 both.
- Back-to-back dependency: instr_valid held high for ADD R3=R1+R2 then ADD R0=R3+R3 (R1=5, R2=3) -> instr_ready low 3 cycles between accepts; second write_data=0x10.
- Reset mid-op: deassert reset_n during EXEC -> no write_en pulse, outputs at reset values immediately, retired_count unchanged at 0; the next instruction executes normally.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: multi-cycle register-register instruction sequencer.
// Accepts one packed instruction per handshake, then walks READ -> EXEC -> WB.
// In those three states it reads two registers, runs a 2-bit-opcode ALU and
// writes the result back to rd. It owns all register-file address and write
// signals.
module reg_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int COUNT_W = 8,
  localparam int INSTR_W = 2 + 3*ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  rs1,
  output logic [ADDR_W-1:0]  rs2,
  output logic [ADDR_W-1:0]  rd,
  output logic               write_en,
  output logic [DATA_W-1:0]  write_data,
  input  logic [DATA_W-1:0]  read_data1,
  input  logic [DATA_W-1:0]  read_data2,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               done,
  output logic [COUNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t              r_state;
  state_t              w_next;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [1:0]          w_op;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_res;
  logic                w_carry;
  logic                w_accept;

  // Handshake and register-file addressing are decoded from registered state
  // only. The ready signal never depends combinationally on instr_valid.
  assign instr_ready = (r_state == S_IDLE);
  assign w_accept    = instr_ready & instr_valid;
  assign w_op        = r_instr[INSTR_W-1 -: 2];
  assign rd          = r_instr[3*ADDR_W-1 -: ADDR_W];
  assign rs1         = r_instr[2*ADDR_W-1 -: ADDR_W];
  assign rs2         = r_instr[ADDR_W-1:0];
  assign write_en    = (r_state == S_WB);
  assign done        = (r_state == S_WB);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: IDLE waits for a handshake; the other states advance one per cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the instruction on accept; the addresses hold until the next accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_instr <= '0;
    else if (w_accept) r_instr <= instr_data;
  end

  // Sample the register-file read ports at the end of READ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == S_READ) begin
      r_a <= read_data1;
      r_b <= read_data2;
    end
  end

  // ALU: the extra MSB of the sum is the carry; for the difference it is the borrow
  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_diff  = {1'b0, r_a} - {1'b0, r_b};
    w_res   = '0;
    w_carry = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
      end
      OP_SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      default: w_res = '0;
    endcase
  end

  // Register the result and flags at the EXEC->WB edge; hold them otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_data <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (r_state == S_EXEC) begin
      write_data <= w_res;
      zero_flag  <= (w_res == '0);
      carry_flag <= w_carry;
    end
  end

  // Count retired instructions at the end of WB; the counter wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              retired_count <= '0;
    else if (r_state == S_WB)  retired_count <= retired_count + 1'b1;
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer. It models the register file, issues directed
// instructions with hand-computed results, and checks each writeback. A
// monitor process scoreboards every write_en cycle.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic       instr_ready;
  logic [1:0] rs1, rs2, rd;
  logic       write_en;
  logic [7:0] write_data;
  logic [7:0] read_data1, read_data2;
  logic       zero_flag, carry_flag, done;
  logic [7:0] retired_count;

  reg_op_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .write_en(write_en),
    .write_data(write_data), .read_data1(read_data1), .read_data2(read_data2),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .done(done),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: combinational reads. A write commits at the clock edge,
  // and the bench can preload a register through the pl_* port.
  logic [7:0] rf [4];
  logic       pl_en = 1'b0;
  logic [1:0] pl_addr = 2'd0;
  logic [7:0] pl_data = 8'h00;
  assign read_data1 = rf[rs1];
  assign read_data2 = rf[rs2];
  always @(posedge clk) begin
    if (write_en)   rf[rd] <= write_data;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic       z;
    logic       c;
    int         cyc;
    int         cnt;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write_en cycle must match the oldest expected writeback
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (write_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_en", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wb_rd", int'(rd), int'(e.rd));
          chk("wb_data", int'(write_data), int'(e.data));
          chk("wb_zero", int'(zero_flag), int'(e.z));
          chk("wb_carry", int'(carry_flag), int'(e.c));
          chk("wb_done", int'(done), 1);
          chk("wb_latency_cycle", cyc, e.cyc);
          chk("wb_retired_before", int'(retired_count), e.cnt);
        end
      end
    end
  end

  // Preload one register (call at a negedge while the sequencer is idle)
  task automatic setreg(input logic [1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present an instruction at a negedge and wait for ready. The writeback is
  // expected 3 cycles after the accepting edge. If hold is set, instr_valid
  // stays high afterwards.
  task automatic issue(input logic [7:0] ins, input logic [7:0] ed, input logic ez,
                       input logic ec, input bit hold, input bit expect_wb,
                       output int lows);
    exp_t e;
    int   guard;
    lows  = 0;
    guard = 0;
    instr_valid = 1'b1;
    instr_data  = ins;
    while (!instr_ready && guard < 20) begin
      lows++;
      guard++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      chk("issue_ready_timeout", 0, 1);
      instr_valid = 1'b0;
    end else begin
      if (expect_wb) begin
        e.rd = ins[5:4]; e.data = ed; e.z = ez; e.c = ec;
        e.cyc = cyc + 3; e.cnt = exp_cnt;
        sb.push_back(e);
        exp_cnt = (exp_cnt + 1) % 256;
      end
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || !instr_ready) && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (sb.size() != 0 || !instr_ready) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  int lows;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_rd", int'(rd), 0);
    chk("rst_rs1", int'(rs1), 0);
    chk("rst_rs2", int'(rs2), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_write_data", int'(write_data), 0);
    chk("rst_zero", int'(zero_flag), 0);
    chk("rst_carry", int'(carry_flag), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_retired", int'(retired_count), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during EXEC: the instruction is discarded and nothing is written
    setreg(2'd1, 8'h05);
    setreg(2'd2, 8'h03);
    issue(8'h36, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, lows);  // now in READ
    @(negedge clk);                                      // now in EXEC
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", int'(instr_ready), 1);
    chk("midrst_write_en", int'(write_en), 0);
    chk("midrst_write_data", int'(write_data), 0);
    chk("midrst_rd", int'(rd), 0);
    chk("midrst_retired", int'(retired_count), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_retired_after", int'(retired_count), 0);

    // ADD R3 = R1 + R2 = 5 + 3
    issue(8'h36, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, lows);
    wait_idle();
    chk("add_retired", int'(retired_count), 1);

    // ADD with carry out and zero result: 0xFF + 0x01
    setreg(2'd1, 8'hFF);
    setreg(2'd2, 8'h01);
    issue(8'h06, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, lows);
    wait_idle();

    // SUB with borrow: 3 - 5; then SUB R3 = R1 - R1
    setreg(2'd1, 8'h03);
    setreg(2'd2, 8'h05);
    issue(8'h66, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, lows);
    wait_idle();
    issue(8'h75, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, lows);
    wait_idle();

    // AND and OR of 0xF0 and 0x3C
    setreg(2'd1, 8'hF0);
    setreg(2'd2, 8'h3C);
    issue(8'hB6, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, lows);
    wait_idle();
    issue(8'hC6, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1, lows);
    wait_idle();

    // Back-to-back with a RAW dependency: R3 = R1 + R2, then R0 = R3 + R3
    setreg(2'd1, 8'h05);
    setreg(2'd2, 8'h03);
    issue(8'h36, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, lows);
    issue(8'h0F, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, lows);
    chk("b2b_ready_low_cycles", lows, 3);
    wait_idle();

    chk("final_retired", int'(retired_count), exp_cnt);
    chk("final_write_en_low", int'(write_en), 0);
    chk("final_data_held", int'(write_data), 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
